// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave in front of a word-addressed on-chip SRAM.
// Read and write channels run independent FSMs with programmable response latency.
module axi_lite_sram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LAT      = 1,
  parameter int          WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        rready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready
);

  localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          RCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int          WCNT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  r_state_t          r_state_reg, r_state_next;
  logic [RCNT_W-1:0] r_cnt_reg;
  logic [31:0]       ar_addr_reg;
  logic [31:0]       rdata_reg;
  logic [1:0]        rresp_reg;
  logic              ar_take, rd_sample;

  w_state_t          w_state_reg, w_state_next;
  logic [WCNT_W-1:0] w_cnt_reg;
  logic [31:0]       aw_addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              aw_got_reg, w_got_reg;
  logic [1:0]        bresp_reg;
  logic              aw_take, w_take, wr_commit;

  // The offset compare uses every bit of the 32-bit difference, so addresses
  // below the base (which wrap to huge offsets) are also rejected by it.
  logic [31:0]      rd_off, wr_off;
  logic             rd_hit, wr_hit;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_off = ar_addr_reg - BASE_ADDR;
  assign wr_off = aw_addr_reg - BASE_ADDR;
  assign rd_hit = (ar_addr_reg >= BASE_ADDR) && (rd_off < SPAN) && (ar_addr_reg[1:0] == 2'b00);
  assign wr_hit = (aw_addr_reg >= BASE_ADDR) && (wr_off < SPAN) && (aw_addr_reg[1:0] == 2'b00);
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state_reg <= R_IDLE;
    else     r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    arready      = 1'b0;
    ar_take      = 1'b0;
    rd_sample    = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        arready = !rst;
        if (arvalid && !rst) begin
          ar_take      = 1'b1;
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_reg == '0) begin
          rd_sample    = 1'b1;
          r_state_next = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_reg   <= '0;
      ar_addr_reg <= '0;
      rdata_reg   <= '0;
      rresp_reg   <= OKAY;
    end else begin
      if (ar_take) begin
        ar_addr_reg <= araddr;
        r_cnt_reg   <= RCNT_W'(RD_LAT - 1);
      end else if (r_state_reg == R_WAIT && r_cnt_reg != '0) begin
        r_cnt_reg <= r_cnt_reg - 1'b1;
      end
      if (rd_sample) begin
        rdata_reg <= rd_hit ? mem[rd_idx] : 32'h0;
        rresp_reg <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  assign rvalid = (r_state_reg == R_RESP);
  assign rdata  = rdata_reg;
  assign rresp  = rresp_reg;

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) w_state_reg <= W_IDLE;
    else     w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    aw_take      = 1'b0;
    w_take       = 1'b0;
    wr_commit    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        awready = !aw_got_reg && !rst;
        wready  = !w_got_reg && !rst;
        aw_take = awvalid && awready;
        w_take  = wvalid && wready;
        if ((aw_got_reg || aw_take) && (w_got_reg || w_take)) w_state_next = W_WAIT;
      end
      W_WAIT: begin
        if (w_cnt_reg == '0) begin
          wr_commit    = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      aw_addr_reg <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      w_cnt_reg   <= '0;
      bresp_reg   <= OKAY;
    end else begin
      if (aw_take) begin
        aw_addr_reg <= awaddr;
        aw_got_reg  <= 1'b1;
      end
      if (w_take) begin
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
        w_got_reg <= 1'b1;
      end
      if (w_state_reg == W_IDLE && w_state_next == W_WAIT) begin
        w_cnt_reg <= WCNT_W'(WR_LAT - 1);
      end else if (w_state_reg == W_WAIT && w_cnt_reg != '0) begin
        w_cnt_reg <= w_cnt_reg - 1'b1;
      end
      if (wr_commit) bresp_reg <= wr_hit ? OKAY : SLVERR;
      if (w_state_reg == W_RESP && bready) begin
        aw_got_reg <= 1'b0;
        w_got_reg  <= 1'b0;
      end
    end
  end

  // Array is never reset; only lanes with their strobe set are written.
  always_ff @(posedge clk) begin
    if (wr_commit && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_reg[b]) mem[wr_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
      end
    end
  end

  assign bvalid = (w_state_reg == W_RESP);
  assign bresp  = bresp_reg;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: vector table of single transactions plus
// hand-written sequences for stalls, split AW/W, reset aborts and back-to-back reads.
module tb_axi_lite_sram;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;

  axi_lite_sram #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h8000_0000),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arvalid(arvalid),
    .araddr (araddr),
    .arready(arready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .rresp  (rresp),
    .rready (rready),
    .awvalid(awvalid),
    .awaddr (awaddr),
    .awready(awready),
    .wvalid (wvalid),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wready (wready),
    .bvalid (bvalid),
    .bresp  (bresp),
    .bready (bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the R handshake.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    arvalid = 1'b1;
    araddr  = addr;
    rready  = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept_in_time", 32'(n < 20), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat);
    int   n;
    logic aw_hs, w_hs;
    awvalid = 1'b1;
    awaddr  = addr;
    wvalid  = 1'b1;
    wdata   = data;
    wstrb   = strb;
    bready  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    chk("aw_w_accept_in_time", 32'(n < 20), 32'd1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp = bresp;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    int          hs_cyc[4];
    int          n_hs;
    int          n_r;
    bit          hs;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDE22_BE44, 2'b00};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[5]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h5555_5555, 4'hF, 32'h0,         2'b00};
    vecs[7]  = '{1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b10};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h5555_5555, 2'b00};
    vecs[9]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[10] = '{1'b1, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0,         2'b00};
    vecs[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 2'b00};
    vecs[12] = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 32'h0,         2'b00};
    vecs[13] = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'h0, 32'h0,         2'b00};
    vecs[14] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'hAABB_CCDD, 2'b00};
    vecs[15] = '{1'b1, 32'h8000_0020, 32'h7700_0000, 4'h8, 32'h0,         2'b00};
    vecs[16] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h77BB_CCDD, 2'b00};
    vecs[17] = '{1'b1, 32'h8000_0026, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};

    rst = 1'b1;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready",  wready,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_rresp",   rresp,   0);
    chk("rst_bresp",   bresp,   0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", arready, 1);
    chk("idle_awready", awready, 1);
    chk("idle_wready",  wready,  1);

    // Vector table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        $display("vec %0d WRITE addr=0x%08h data=0x%08h strb=%h bresp=%b lat=%0d",
                 i, vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_wlat", i), lat, WR_LAT);
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        $display("vec %0d READ  addr=0x%08h rdata=0x%08h rresp=%b lat=%0d",
                 i, vecs[i].addr, d, r, lat);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rlat", i), lat, RD_LAT);
      end
    end

    // rready held low: response must hold, no new AR accepted
    chk("stall_arready_before", arready, 1);
    arvalid = 1'b1; araddr = 32'h8000_0010; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rlat", n, RD_LAT);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_rvalid", k), rvalid, 1);
      chk($sformatf("stall%0d_rdata", k), rdata, 32'hDE22_BE44);
      chk($sformatf("stall%0d_arready", k), arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    $display("stall read addr=0x80000010 released after 5 cycles");
    chk("stall_rvalid_cleared", rvalid, 0);
    chk("stall_arready_back", arready, 1);

    // W two cycles ahead of AW
    wvalid = 1'b1; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; bready = 1'b1;
    chk("wfirst_wready", wready, 1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_low", wready, 0);
    chk("wfirst_awready_high", awready, 1);
    @(negedge clk);
    chk("wfirst_no_bvalid", bvalid, 0);
    awvalid = 1'b1; awaddr = 32'h8000_0040;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_awready_low", awready, 0);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wfirst_wlat", n, WR_LAT);
    chk("wfirst_bresp", 32'(bresp), 0);
    @(negedge clk);
    $display("split write addr=0x80000040 data=0xa5a50f0f bresp=%b", bresp);
    do_read(32'h8000_0040, d, r, lat);
    $display("split readback addr=0x80000040 rdata=0x%08h rresp=%b", d, r);
    chk("wfirst_readback", d, 32'hA5A5_0F0F);

    // Reset while both channels are waiting
    do_write(32'h8000_0050, 32'h0101_0101, 4'hF, r, lat);
    chk("abort_prewrite_bresp", 32'(r), 0);
    arvalid = 1'b1; araddr = 32'h8000_0050; rready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h8000_0050;
    wvalid  = 1'b1; wdata  = 32'hFFFF_FFFF; wstrb = 4'hF; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("abort_in_rwait", arready, 0);
    chk("abort_in_wwait", awready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_bvalid", bvalid, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_arready_in_rst", arready, 0);
    chk("abort_wready_in_rst", wready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_arready_idle", arready, 1);
    chk("abort_awready_idle", awready, 1);
    chk("abort_wready_idle", wready, 1);
    repeat (4) @(negedge clk);
    chk("abort_no_late_bvalid", bvalid, 0);
    chk("abort_no_late_rvalid", rvalid, 0);
    do_read(32'h8000_0050, d, r, lat);
    $display("abort readback addr=0x80000050 rdata=0x%08h rresp=%b", d, r);
    chk("abort_readback", d, 32'h0101_0101);

    // Back-to-back reads with arvalid held
    for (int i = 0; i < 4; i++) begin
      do_write(32'h8000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, r, lat);
      chk($sformatf("b2b_prewrite%0d", i), 32'(r), 0);
    end
    n_hs = 0; n_r = 0;
    arvalid = 1'b1; araddr = 32'h8000_0100; rready = 1'b1;
    for (int c = 0; c < 80 && n_r < 4; c++) begin
      hs = arvalid && arready;
      if (hs && n_hs < 4) hs_cyc[n_hs] = c;
      @(negedge clk);
      if (hs) begin
        n_hs++;
        if (n_hs < 4) araddr = 32'h8000_0100 + 32'(4 * n_hs);
        else          arvalid = 1'b0;
      end
      if (rvalid) begin
        $display("b2b read %0d rdata=0x%08h rresp=%b", n_r, rdata, rresp);
        chk($sformatf("b2b%0d_rdata", n_r), rdata, 32'hC0DE_0000 + 32'(n_r));
        chk($sformatf("b2b%0d_rresp", n_r), 32'(rresp), 0);
        n_r++;
      end
    end
    arvalid = 1'b0;
    chk("b2b_all_returned", n_r, 4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_period%0d", i), hs_cyc[i+1] - hs_cyc[i], RD_LAT + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
